// File: rtl/obi_data_responder.sv
// obi_data_responder: responder end of the Ibex LSU data bus (req/gnt/rvalid).
// Small byte-enabled word memory with programmable grant wait-states, a
// fixed-latency response pipe, an address-access log and a saturating
// grant counter exported for the contract checker.
module obi_data_responder #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned GNT_DELAY = 0,
  parameter int unsigned RESP_LAT  = 1,
  parameter int unsigned LOG_DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [3:0]             data_be_i,
  input  logic [31:0]            data_addr_i,
  input  logic [31:0]            data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [31:0]            data_rdata_o,
  output logic                   data_err_o,
  output logic [DEPTH*32-1:0]    mem_data_o,
  output logic [LOG_DEPTH*32-1:0] mem_addr_o,
  output logic [31:0]            access_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  logic [31:0]         mem [DEPTH];
  logic [31:0]         log_q [LOG_DEPTH];
  logic [2:0]          wait_cnt;
  logic [31:0]         access_cnt;
  logic [RESP_LAT-1:0] pipe_valid;
  logic [RESP_LAT-1:0] pipe_err;
  logic [31:0]         pipe_rdata [RESP_LAT];

  logic                gnt;
  logic                in_range;
  logic [31:0]         offset;
  logic [IDX_W-1:0]    idx;
  logic [31:0]         rd_word;

  // Grant, range check and word index for the current request
  always_comb begin
    gnt      = rst_ni & data_req_i & (wait_cnt == 3'(GNT_DELAY));
    in_range = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, data_addr_i} < LIMIT);
    offset   = data_addr_i - BASE_ADDR;
    idx      = offset[IDX_W+1:2];
    rd_word  = mem[idx];
  end

  assign data_gnt_o = gnt;

  // Wait-state counter: counts cycles of an ungranted request, clears on grant or drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (!data_req_i || gnt) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // Backing memory: byte-enabled write on the grant edge of an in-range write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (gnt && data_we_i && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipe: stage 0 captures the grant-cycle result, later stages shift
  // it towards the outputs; idle stages carry zeros so rdata/err read 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int unsigned i = 0; i < RESP_LAT; i++) begin
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= gnt;
      pipe_err[0]   <= gnt & ~in_range;
      pipe_rdata[0] <= (gnt && !data_we_i && in_range) ? rd_word : '0;
      for (int unsigned i = 1; i < RESP_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign data_rvalid_o = pipe_valid[RESP_LAT-1];
  assign data_err_o    = pipe_err[RESP_LAT-1];
  assign data_rdata_o  = pipe_rdata[RESP_LAT-1];

  // Access log: every grant (errors included) pushes its address in at entry 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
        log_q[i] <= '0;
      end
    end else if (gnt) begin
      log_q[0] <= data_addr_i;
      for (int unsigned i = 1; i < LOG_DEPTH; i++) begin
        log_q[i] <= log_q[i-1];
      end
    end
  end

  // Saturating grant counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      access_cnt <= '0;
    end else if (gnt && (access_cnt != '1)) begin
      access_cnt <= access_cnt + 32'd1;
    end
  end

  assign access_cnt_o = access_cnt;

  // Flatten memory and log arrays onto the export buses
  always_comb begin
    mem_data_o = '0;
    mem_addr_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_data_o[32*i +: 32] = mem[i];
    end
    for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
      mem_addr_o[32*i +: 32] = log_q[i];
    end
  end

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed self-checking bench for obi_data_responder: three instances cover
// the default configuration, GNT_DELAY=3 and RESP_LAT=2.
module tb_obi_data_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic req_def, req_dly, req_lat;
  logic gnt_def, gnt_dly, gnt_lat;
  logic rv_def, rv_dly, rv_lat;
  logic err_def, err_dly, err_lat;
  logic [31:0] rd_def, rd_dly, rd_lat;
  logic [31:0] cnt_def, cnt_dly, cnt_lat;
  logic [8*32-1:0]  mem_def, mem_dly, mem_lat;
  logic [32*32-1:0] log_def, log_dly, log_lat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obi_data_responder u_def (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_def), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt_def), .data_rvalid_o(rv_def), .data_rdata_o(rd_def),
    .data_err_o(err_def), .mem_data_o(mem_def), .mem_addr_o(log_def),
    .access_cnt_o(cnt_def)
  );

  obi_data_responder #(.GNT_DELAY(3)) u_dly (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_dly), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt_dly), .data_rvalid_o(rv_dly), .data_rdata_o(rd_dly),
    .data_err_o(err_dly), .mem_data_o(mem_dly), .mem_addr_o(log_dly),
    .access_cnt_o(cnt_dly)
  );

  obi_data_responder #(.RESP_LAT(2)) u_lat (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req_lat), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt_lat), .data_rvalid_o(rv_lat), .data_rdata_o(rd_lat),
    .data_err_o(err_lat), .mem_data_o(mem_lat), .mem_addr_o(log_lat),
    .access_cnt_o(cnt_lat)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 32'h00BB_00DD, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_001C, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_001C, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[8]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; req_def = 1'b0; req_dly = 1'b0; req_lat = 1'b0;
    we = 1'b0; be = 4'h0; addr = '0; wdata = '0;

    // ---- reset state ----
    tick();
    req_def = 1'b1;
    #1;
    check_eq("rst gnt forced 0", 32'(gnt_def), 32'h0);
    check_eq("rst rvalid", 32'(rv_def), 32'h0);
    check_eq("rst rdata", rd_def, 32'h0);
    check_eq("rst access_cnt", cnt_def, 32'h0);
    check_eq("rst log0", log_def[31:0], 32'h0);
    req_def = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ---- default instance: directed single transactions ----
    for (int i = 0; i < 11; i++) begin
      we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; be = tbl[i].be;
      req_def = 1'b1;
      #1;
      check_eq($sformatf("def%0d gnt", i), 32'(gnt_def), 32'h1);
      tick();
      req_def = 1'b0;
      check_eq($sformatf("def%0d rvalid", i), 32'(rv_def), 32'h1);
      check_eq($sformatf("def%0d rdata", i), rd_def, tbl[i].rdata);
      check_eq($sformatf("def%0d err", i), 32'(err_def), 32'(tbl[i].err));
      tick();
      check_eq($sformatf("def%0d rvalid drop", i), 32'(rv_def), 32'h0);
    end
    check_eq("def mem word0", mem_def[0*32 +: 32], 32'h0);
    check_eq("def mem word2", mem_def[2*32 +: 32], 32'h00BB_00DD);
    check_eq("def mem word3", mem_def[3*32 +: 32], 32'h0);
    check_eq("def mem word7", mem_def[7*32 +: 32], 32'h1234_5678);
    check_eq("def access_cnt", cnt_def, 32'd11);
    check_eq("def log0", log_def[0*32 +: 32], 32'hFFFF_FFFC);
    check_eq("def log1", log_def[1*32 +: 32], 32'h0000_0000);
    check_eq("def log2", log_def[2*32 +: 32], 32'h0000_0040);

    // ---- write then read of the same word on consecutive grants ----
    req_def = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h1122_3344; be = 4'hF;
    #1;
    check_eq("b2b wr gnt", 32'(gnt_def), 32'h1);
    tick();
    we = 1'b0;
    #1;
    check_eq("b2b rd gnt", 32'(gnt_def), 32'h1);
    check_eq("b2b wr rvalid", 32'(rv_def), 32'h1);
    tick();
    req_def = 1'b0;
    check_eq("b2b rd rvalid", 32'(rv_def), 32'h1);
    check_eq("b2b rd rdata", rd_def, 32'h1122_3344);
    check_eq("b2b access_cnt", cnt_def, 32'd13);
    tick();

    // ---- 33 back-to-back grants fill and overflow the log ----
    we = 1'b0; be = 4'hF;
    req_def = 1'b1;
    for (int i = 0; i < 33; i++) begin
      addr = 32'h100 + 32'(4 * i);
      tick();
    end
    req_def = 1'b0;
    check_eq("log33 err", 32'(err_def), 32'h1);
    check_eq("log33 log0 newest", log_def[0*32 +: 32], 32'h0000_0180);
    check_eq("log33 log31 oldest", log_def[31*32 +: 32], 32'h0000_0104);
    check_eq("log33 access_cnt", cnt_def, 32'd46);
    tick();

    // ---- GNT_DELAY=3: held request granted in 4th cycle only ----
    we = 1'b0; addr = 32'h4; be = 4'hF;
    req_dly = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("dly held c%0d gnt", c), 32'(gnt_dly), (c == 3) ? 32'h1 : 32'h0);
      tick();
    end
    #1;
    check_eq("dly after gnt", 32'(gnt_dly), 32'h0);
    check_eq("dly rvalid", 32'(rv_dly), 32'h1);
    check_eq("dly err", 32'(err_dly), 32'h0);
    req_dly = 1'b0;
    tick();
    check_eq("dly access_cnt 1", cnt_dly, 32'd1);

    // request dropped after 2 cycles: discarded
    req_dly = 1'b1;
    tick();
    tick();
    req_dly = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("dly drop c%0d rvalid", c), 32'(rv_dly), 32'h0);
      tick();
    end
    check_eq("dly drop access_cnt", cnt_dly, 32'd1);

    // new request starts counting from zero again
    req_dly = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("dly rereq c%0d gnt", c), 32'(gnt_dly), (c == 3) ? 32'h1 : 32'h0);
      tick();
    end
    req_dly = 1'b0;
    check_eq("dly rereq rvalid", 32'(rv_dly), 32'h1);
    tick();

    // ---- RESP_LAT=2: preload words then pipelined reads ----
    we = 1'b1; be = 4'hF;
    req_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(4 * i); wdata = 32'hA0A0_0000 + 32'(i);
      tick();
    end
    req_lat = 1'b0;
    tick(); tick(); tick();
    check_eq("lat preload word1", mem_lat[1*32 +: 32], 32'hA0A0_0001);

    we = 1'b0; addr = 32'h0; req_lat = 1'b1;
    #1;
    check_eq("lat r0 gnt", 32'(gnt_lat), 32'h1);
    tick();
    check_eq("lat r1 rvalid", 32'(rv_lat), 32'h0);
    addr = 32'h4;
    tick();
    check_eq("lat r2 rvalid", 32'(rv_lat), 32'h1);
    check_eq("lat r2 rdata", rd_lat, 32'hA0A0_0000);
    addr = 32'h8;
    tick();
    req_lat = 1'b0;
    check_eq("lat r3 rvalid", 32'(rv_lat), 32'h1);
    check_eq("lat r3 rdata", rd_lat, 32'hA0A0_0001);
    tick();
    check_eq("lat r4 rvalid", 32'(rv_lat), 32'h1);
    check_eq("lat r4 rdata", rd_lat, 32'hA0A0_0002);
    tick();
    check_eq("lat r5 rvalid", 32'(rv_lat), 32'h0);
    check_eq("lat access_cnt", cnt_lat, 32'd6);
    tick();

    // ---- reset with two responses pending ----
    addr = 32'h0; req_lat = 1'b1;
    tick();
    addr = 32'h4;
    tick();
    req_lat = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid rvalid", 32'(rv_lat), 32'h0);
    check_eq("rstmid mem word0", mem_lat[0*32 +: 32], 32'h0);
    check_eq("rstmid log0", log_lat[0*32 +: 32], 32'h0);
    check_eq("rstmid access_cnt", cnt_lat, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("rstmid post c%0d rvalid", c), 32'(rv_lat), 32'h0);
    end
    check_eq("rstmid def mem word2", mem_def[2*32 +: 32], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
